// File: rtl/led_arbiter_if.sv
// LED arbiter bus: requester levels and patterns in, owner/busy/LED drive out.
interface led_arbiter_if;
    logic [2:0] req;
    logic [7:0] pat0;
    logic [7:0] pat1;
    logic [7:0] pat2;
    logic [2:0] grant;
    logic       busy;
    logic [7:0] led;

    // Requester side: drives requests and patterns, observes ownership.
    modport master (
        output req, pat0, pat1, pat2,
        input  grant, busy, led
    );

    // Arbiter side.
    modport slave (
        input  req, pat0, pat1, pat2,
        output grant, busy, led
    );
endinterface

// File: rtl/led_arbiter.sv
// Round-robin owner arbitration for a shared 8-bit LED bank with a minimum
// hold time in display ticks and preemption once the hold has expired.
// Optional idle heartbeat (rotating single LED) built in with macro
// LED_ARB_HEARTBEAT_EN; without it the LEDs are dark while idle.
module led_arbiter #(
    parameter int TICK_DIV   = 25000000,
    parameter int HOLD_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    led_arbiter_if.slave bus
);
    localparam int             CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]     HOLD    = 4'(HOLD_TICKS);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hold_q, hold_d;
    logic [2:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [1:0]       last_q, last_d;   // previous/current owner index
    logic [7:0]       led_q, led_d;
    logic             tick;
    logic [1:0]       win;
    logic [2:0]       others;
    logic [7:0]       pat_sel;
    logic [7:0]       idle_led;
`ifdef LED_ARB_HEARTBEAT_EN
    logic [7:0]       idle_q, idle_d;
`endif

    // First requester found searching from from+1 (mod 3); the owner itself
    // comes last, so preemption naturally picks someone else.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] from);
        logic [1:0] sel;
        int         k;
        sel = from;
        for (int i = 3; i >= 1; i--) begin
            k = (int'(from) + i) % 3;
            if (r[2'(k)]) sel = 2'(k);
        end
        return sel;
    endfunction

    // Next-state: tick divider, ownership decisions, hold counting, LED mux.
    always_comb begin
        tick    = (cnt_q == CNT_MAX);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        win     = rr_pick(bus.req, last_q);
        others  = bus.req & ~grant_q;
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;

        case (last_q)
            2'd0:    pat_sel = bus.pat0;
            2'd1:    pat_sel = bus.pat1;
            default: pat_sel = bus.pat2;
        endcase

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = OWN;
                    grant_d = 3'b001 << win;
                    last_d  = win;
                    hold_d  = '0;
                end
            end
            default: begin
                if (!bus.req[last_q] || (hold_q == HOLD && |others)) begin
                    // Release or preempt; a tick on this edge is not counted.
                    hold_d = '0;
                    if (|others) begin
                        grant_d = 3'b001 << win;
                        last_d  = win;
                    end else begin
                        state_d = IDLE;
                        grant_d = 3'b000;
                    end
                end else if (tick && hold_q < HOLD) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase

        busy_d = |grant_d;

`ifdef LED_ARB_HEARTBEAT_EN
        idle_d   = (state_q == IDLE && tick) ? {idle_q[6:0], idle_q[7]} : idle_q;
        idle_led = idle_d;
`else
        idle_led = 8'h00;
`endif
        // LED follows the owner's pattern one cycle late; idle shows heartbeat.
        led_d = (state_q == OWN) ? pat_sel : idle_led;
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            grant_q <= 3'b000;
            busy_q  <= 1'b0;
            last_q  <= 2'd2;
`ifdef LED_ARB_HEARTBEAT_EN
            idle_q  <= 8'h01;
            led_q   <= 8'h01;
`else
            led_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            led_q   <= led_d;
`ifdef LED_ARB_HEARTBEAT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.led   = led_q;
endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter (TICK_DIV=4, HOLD_TICKS=2): directed
// scenarios plus randomized traffic against a cycle-level ownership model.
module tb_led_arbiter;
    localparam int TD = 4;
    localparam int HT = 2;
`ifdef LED_ARB_HEARTBEAT_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif
    localparam logic [7:0] LED_RST = HB ? 8'h01 : 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_arbiter_if bus();
    led_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner as index (-1 = nobody), counters as plain ints.
    int         m_owner = -1;
    int         m_last  = 2;
    int         m_hold  = 0;
    int         m_cnt   = 0;
    logic [7:0] m_idle  = 8'h01;
    logic [7:0] m_led   = LED_RST;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Round-robin: first requester after 'from', excluding 'skip'.
    function automatic int next_req(input logic [2:0] r, input int from, input int skip);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (from + k) % 3;
            if (r[idx] && idx != skip) return idx;
        end
        return -1;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_step(input logic r, input logic [2:0] rq, input logic [7:0] p0,
                              input logic [7:0] p1, input logic [7:0] p2);
        logic [7:0] pats [3];
        bit tick;
        int nxt;
        pats[0] = p0; pats[1] = p1; pats[2] = p2;
        if (r) begin
            m_owner = -1; m_last = 2; m_hold = 0; m_cnt = 0;
            m_idle = 8'h01; m_led = LED_RST;
            return;
        end
        tick = (m_cnt == TD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (m_owner >= 0) begin
            m_led = pats[m_owner];
        end else begin
            if (tick) m_idle = {m_idle[6:0], m_idle[7]};
            m_led = HB ? m_idle : 8'h00;
        end
        if (m_owner < 0) begin
            if (rq != 3'b000) begin
                m_owner = next_req(rq, m_last, -1);
                m_last = m_owner; m_hold = 0;
            end
        end else begin
            nxt = next_req(rq, m_owner, m_owner);
            if (!rq[m_owner] || (m_hold == HT && nxt >= 0)) begin
                m_hold = 0;
                m_owner = nxt;
                if (nxt >= 0) m_last = nxt;
            end else if (tick && m_hold < HT) begin
                m_hold++;
            end
        end
    endtask

    // Drive inputs at the falling edge, advance model, check after the rising edge.
    task automatic cycle(input logic r, input logic [2:0] rq, input logic [7:0] p0,
                         input logic [7:0] p1, input logic [7:0] p2);
        logic [2:0] eg;
        @(negedge clk);
        rst = r; bus.req = rq; bus.pat0 = p0; bus.pat1 = p1; bus.pat2 = p2;
        model_step(r, rq, p0, p1, p2);
        @(posedge clk);
        #1;
        eg = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("busy",  32'(bus.busy),  32'(m_owner >= 0));
        chk("led",   32'(bus.led),   32'(m_led));
    endtask

    logic [2:0] seq [$];
    logic [2:0] prev_g;
    logic [2:0] rq;
    logic [7:0] rp0, rp1, rp2;

    initial begin
        bus.req = 3'b000; bus.pat0 = 8'h11; bus.pat1 = 8'h22; bus.pat2 = 8'h33;

        // Reset state.
        repeat (3) cycle(1'b1, 3'b000, 8'h11, 8'h22, 8'h33);
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        chk("rst_led",   32'(bus.led),   32'(LED_RST));

        // Single requester: grant next edge, pattern the edge after, clean release.
        cycle(1'b0, 3'b010, 8'h11, 8'hA5, 8'h33);
        chk("s1_grant", 32'(bus.grant), 32'h2);
        chk("s1_busy",  32'(bus.busy),  32'h1);
        cycle(1'b0, 3'b010, 8'h11, 8'hA5, 8'h33);
        chk("s1_led",   32'(bus.led),   32'hA5);
        repeat (3) cycle(1'b0, 3'b010, 8'h11, 8'hA5, 8'h33);
        cycle(1'b0, 3'b000, 8'h11, 8'hA5, 8'h33);
        chk("s1_rel_grant", 32'(bus.grant), 32'h0);
        chk("s1_rel_busy",  32'(bus.busy),  32'h0);

        // Contention from reset: rotation 001,010,100,001.
        cycle(1'b1, 3'b111, 8'h11, 8'h22, 8'h33);
        prev_g = 3'b000;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 3'b111, 8'h11, 8'h22, 8'h33);
            if (bus.grant != prev_g) seq.push_back(bus.grant);
            prev_g = bus.grant;
        end
        chk("rr_len", 32'(seq.size() >= 4), 32'h1);
        if (seq.size() >= 4) begin
            chk("rr_0", 32'(seq[0]), 32'h1);
            chk("rr_1", 32'(seq[1]), 32'h2);
            chk("rr_2", 32'(seq[2]), 32'h4);
            chk("rr_3", 32'(seq[3]), 32'h1);
        end

        // Reset mid-ownership (owner 2), then requester 0 wins first.
        cycle(1'b1, 3'b000, 8'h11, 8'h22, 8'h33);
        cycle(1'b0, 3'b000, 8'h11, 8'h22, 8'h33);
        cycle(1'b0, 3'b100, 8'h11, 8'h22, 8'h33);
        chk("r32_own2", 32'(bus.grant), 32'h4);
        cycle(1'b1, 3'b100, 8'h11, 8'h22, 8'h33);
        chk("r32_grant", 32'(bus.grant), 32'h0);
        chk("r32_busy",  32'(bus.busy),  32'h0);
        chk("r32_led",   32'(bus.led),   32'(LED_RST));
        cycle(1'b0, 3'b101, 8'h11, 8'h22, 8'h33);
        chk("r32_first", 32'(bus.grant), 32'h1);

        // Early release of owner 1 with req0 pending: straight handover.
        cycle(1'b0, 3'b000, 8'h11, 8'h22, 8'h33);
        cycle(1'b0, 3'b010, 8'h11, 8'h22, 8'h33);
        chk("r30_own1", 32'(bus.grant), 32'h2);
        cycle(1'b0, 3'b001, 8'h11, 8'h22, 8'h33);
        chk("r30_hand", 32'(bus.grant), 32'h1);
        chk("r30_busy", 32'(bus.busy),  32'h1);

        // Idle heartbeat / dark LEDs.
        cycle(1'b0, 3'b000, 8'h11, 8'h22, 8'h33);
        repeat (40) cycle(1'b0, 3'b000, 8'h11, 8'h22, 8'h33);

        // Randomized traffic with slowly changing requests and rare resets.
        rq = 3'b000; rp0 = 8'h00; rp1 = 8'h00; rp2 = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) rq = 3'($urandom_range(0, 7));
            rp0 = 8'($urandom); rp1 = 8'($urandom); rp2 = 8'($urandom);
            cycle($urandom_range(0, 80) == 0, rq, rp0, rp1, rp2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per display tick (legal range 2..2^25).
REQ-002 SHALL have parameter HOLD_TICKS, default 4, meaning the minimum ticks an owner keeps the LEDs before it can be preempted (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 3 bits: level request per requester, index 0..2.
REQ-006 SHALL have ports pat0, pat1 and pat2, input, 8 bits each: the LED pattern of requester 0, 1 and 2.
REQ-007 SHALL have port grant, output, 3 bits: one-hot current owner, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while any requester owns the LEDs, registered.
REQ-009 SHALL have port led, output, 8 bits: the registered LED drive.

Function
REQ-010 SHALL run a free-running tick counter 0..TICK_DIV-1 and pulse tick for one cycle when the count equals TICK_DIV-1, wrapping to 0 on the next cycle.
REQ-011 SHALL implement two states.
- IDLE: no owner.
- OWN: one owner.
REQ-012 SHALL, in IDLE with req nonzero, register the winner in grant on the next edge and enter OWN, with busy=1 and hold_cnt=0.
REQ-013 SHALL select the winner round-robin: search starts at index last+1 mod 3, where last is the previous owner.
REQ-014 SHALL, in OWN, drive led with pat[owner] sampled one cycle earlier, giving 1-cycle latency from pat to led.
REQ-015 SHALL increment hold_cnt on each tick in OWN, saturating at HOLD_TICKS; a new grant clears hold_cnt, and the tick counter is not cleared.
REQ-016 SHALL release immediately when req[owner] drops, at any hold_cnt.
- If another request is pending: grant it round-robin on the same edge, staying in OWN.
- Otherwise: go to IDLE with grant=0 and busy=0.
REQ-017 SHALL, when hold_cnt==HOLD_TICKS and another requester is pending, preempt the owner on the next edge by granting the next pending requester round-robin, even if req[owner] is still high.
REQ-018 SHALL keep the owner indefinitely while hold_cnt<HOLD_TICKS and req[owner]=1, or while no other request is pending.
REQ-019 SHALL handle a tick coinciding with a grant change by giving the new owner hold_cnt=0; that tick is not counted.
REQ-020 SHALL keep grant one-hot or zero at all times, with busy equal to the OR of grant.
REQ-021 SHALL, in IDLE, drive led with the idle pattern per REQ-025/REQ-026.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, set all of the following on that edge, overriding all other activity including a switch in progress.
- State: IDLE.
- Counters: tick counter=0, hold_cnt=0.
- Outputs: grant=3'b000, busy=0, last=2 (so requester 0 wins first).
- LEDs: led=8'h01 if LED_ARB_HEARTBEAT_EN is defined, else 8'h00.
REQ-023 SHALL ignore req while rst=1 and evaluate requests from the first edge after rst falls.

Configuration
REQ-024 SHALL compile the idle heartbeat in or out with macro LED_ARB_HEARTBEAT_EN.
REQ-025 SHALL, with LED_ARB_HEARTBEAT_EN defined, keep an 8-bit idle register, reset 8'h01, rotated left by one (bit7 to bit0) on every tick in IDLE and frozen in OWN; in IDLE, led equals this register.
REQ-026 SHALL, without LED_ARB_HEARTBEAT_EN, omit the idle register entirely and drive led=8'h00 in IDLE.

Verification (TICK_DIV=4, HOLD_TICKS=2)
REQ-027 SHALL cover single requester: req=3'b010, pat1=8'hA5 -> grant=3'b010 and busy=1 one edge later; led=8'hA5 the edge after; req drops -> grant=0 and busy=0 next edge.
REQ-028 SHALL cover reset-released contention: req=3'b111 from reset -> grant sequence 001, 010, 100, 001, with each switch exactly at the edge following hold_cnt reaching 2.
REQ-029 SHALL cover no preemption before hold: owner 0 holding, req2 raised while hold_cnt=1 -> grant stays 001 until hold_cnt=2, then becomes 100 next edge.
REQ-030 SHALL cover early release: owner 1 drops req at hold_cnt=0 while req0 is high -> grant=001 on the next edge with no IDLE cycle.
REQ-031 SHALL cover heartbeat with macro defined and idle: led sequence 01, 02, 04, ..., 80, 01 at one step per 4 cycles; without the macro, led holds 00.
REQ-032 SHALL cover reset mid-ownership: rst pulsed while grant=100 -> next edge grant=0, busy=0, led=reset value; first grant after release goes to requester 0 if pending.
